mold_msg_asm: RTL and testbench
===============================

Name: mold_msg_asm

Overview:
- Sits directly downstream of the MoldUDP64 parser (`top`) and consumes its `mold_msg_*` beat stream.
- Reassembles each MoldUDP64 message, delivered as 1..N 64-bit beats, into one flat, byte-aligned register.
- Emits the complete message with its length as a single-cycle pulse for the ITCH decoder.
- Detects and flags malformed beat sequences: oversize, truncated, orphan and overrun.

Parameters:
- AXI_DATA_W, 64, beat data width in bits.
- AXI_KEEP_W, AXI_DATA_W/8, beat byte-mask width.
- ML_W, 16, message length field width in bits.
- MSG_MAX_LEN, 50, largest message in bytes that can be assembled.
- MSG_W, MSG_MAX_LEN*8, width of the flat message output.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- mold_msg_v_i  in  1  beat valid.
- mold_msg_start_i  in  1  first beat of a message.
- mold_msg_len_i  in  ML_W  message length in bytes; sampled only when v and start are both high.
- mold_msg_mask_i  in  AXI_KEEP_W  valid bytes of the beat; contiguous from bit 0.
- mold_msg_data_i  in  AXI_DATA_W  beat data; byte 0 is [7:0].
- itch_msg_v_o  out  1  one-cycle pulse: message complete.
- itch_msg_len_o  out  ML_W  length of the completed message.
- itch_msg_data_o  out  MSG_W  message bytes; byte k is at [8k+7:8k]; bytes at or beyond len are 0.
- asm_err_ovf_o  out  1  pulse: message dropped because len > MSG_MAX_LEN or len == 0.
- asm_err_trunc_o  out  1  pulse: start arrived before the previous message completed.
- asm_err_orphan_o  out  1  pulse: non-start beat arrived while IDLE.
- asm_err_len_o  out  1  pulse: bytes received exceed the declared length.

Behaviour:
- Reset: the asynchronous nreset clears state to IDLE, all counters to 0, and every output to 0, including the data register. Reset mid-message discards the partial message and raises no error.
- Upstream has no ready, so the block accepts a beat on every cycle where v=1.
- Byte counter cnt_q is ML_W wide. Length register len_q holds the sampled length. Beat byte count is popcount(mask), 0..8.
- State IDLE:
  - v & start with 0 < len <= MAX: clear the buffer, write the beat at offset 0, set cnt = pop, latch len_q.
    - If pop >= len, the message completes on this beat; stay IDLE.
    - Otherwise go to ACC.
  - v & start with len == 0 or len > MAX: pulse ovf. If len > pop, go to DROP; otherwise stay IDLE.
  - v & !start: pulse orphan and ignore the beat.
- State ACC:
  - v & !start: write the valid bytes at byte offset cnt_q; cnt += pop.
  - When cnt + pop == len_q: complete and go to IDLE.
  - When cnt + pop > len_q: complete, writing only the first len_q - cnt bytes, pulse len, go to IDLE.
  - v & start: pulse trunc, discard the partial message, and handle the beat exactly as IDLE v & start does, in the same cycle.
- State DROP: count bytes until cnt + pop >= len_q, then go to IDLE. A start beat in DROP pulses trunc and is handled as in IDLE.
- Completion timing: the completing beat at cycle N gives itch_msg_v_o=1 at N+1 for exactly one cycle. itch_msg_len_o and itch_msg_data_o change only on completion and then hold. Error pulses are also registered with 1-cycle latency.
- Offset write rule: byte j of the beat goes to byte cnt_q + j when j < pop and cnt_q + j < MSG_MAX_LEN. Any write that would exceed MSG_MAX_LEN is suppressed.
- Back-to-back: a message completing at beat N and a start at beat N+1 are legal. Consecutive single-beat messages give a v pulse on every cycle.

Optional Feature:
- Macro MOLD_ASM_CNT_EN.
- When defined, adds two outputs, each 32 bits and cleared by reset:
  - asm_msg_cnt_o counts completed messages.
  - asm_drop_cnt_o counts ovf + trunc + orphan events.
  - Both counters wrap at 2^32 silently.
- When undefined, these ports and registers do not exist.

Decomposition:
- Shared package mold_pkg holds:
  - LEN, ML_W, AXI_DATA_W, AXI_KEEP_W, MSG_MAX_LEN.
  - State enum mold_asm_state_e {IDLE, ACC, DROP}.
  - A popcount function for the keep mask.
- One natural sub-module, mold_asm_place: combinational byte-lane placement of one beat at offset cnt_q into the MSG_W buffer, producing write-enable per byte.

Test Plan:
- Start beat len=16 with data {16{4'hA}}, then a beat of 8 bytes {16{4'hB}} → one cycle later v=1, len=16, bytes 0-7=0xAA, bytes 8-15=0xBB, rest 0.
- Single beat start len=5, mask=8'h1F, data 64'h1122334455 → v=1 next cycle, len=5, data[39:0]=40'h1122334455, upper bits 0; back-to-back repeat gives v on consecutive cycles.
- Start len=60 (> MAX=50), then 7 continuation beats → ovf pulses once, no v, a later valid message assembles correctly.
- Start len=16 with 8 bytes, then a new start len=8 full mask → trunc pulses, v for the len-8 message only.
- Non-start beat while IDLE → orphan pulses, outputs unchanged. Start len=10, then beat mask=8'hFF → len pulses, v with len=10 and bytes 10+ equal 0.
- nreset low during ACC after 8 of 16 bytes, then release and send a full 16-byte message → only the post-reset message is emitted. With MOLD_ASM_CNT_EN, counters read 1 and 0.

Source files
------------

// File: rtl/mold_msg_asm_pkg.sv
// Shared constants, FSM state type and keep-mask popcount for the MoldUDP64
// message assembler.
package mold_pkg;

  localparam int unsigned AXI_DATA_W  = 64;
  localparam int unsigned AXI_KEEP_W  = AXI_DATA_W / 8;
  localparam int unsigned LEN         = AXI_KEEP_W;  // bytes per beat
  localparam int unsigned ML_W        = 16;
  localparam int unsigned MSG_MAX_LEN = 50;
  localparam int unsigned MSG_W       = MSG_MAX_LEN * 8;
  localparam int unsigned POP_W       = $clog2(AXI_KEEP_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DROP = 2'd2
  } mold_asm_state_e;

  function automatic logic [POP_W-1:0] popcount(input logic [AXI_KEEP_W-1:0] mask);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < AXI_KEEP_W; i++) begin
      n = n + POP_W'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mold_msg_asm_if.sv
// Beat stream in, assembled message and error pulses out.
// MOLD_ASM_CNT_EN adds the message and drop counters.
interface mold_msg_asm_if;
  import mold_pkg::*;

  logic                  mold_msg_v_i;
  logic                  mold_msg_start_i;
  logic [ML_W-1:0]       mold_msg_len_i;
  logic [AXI_KEEP_W-1:0] mold_msg_mask_i;
  logic [AXI_DATA_W-1:0] mold_msg_data_i;
  logic                  itch_msg_v_o;
  logic [ML_W-1:0]       itch_msg_len_o;
  logic [MSG_W-1:0]      itch_msg_data_o;
  logic                  asm_err_ovf_o;
  logic                  asm_err_trunc_o;
  logic                  asm_err_orphan_o;
  logic                  asm_err_len_o;
`ifdef MOLD_ASM_CNT_EN
  logic [31:0]           asm_msg_cnt_o;
  logic [31:0]           asm_drop_cnt_o;
`endif

  modport master (
    output mold_msg_v_i, mold_msg_start_i, mold_msg_len_i, mold_msg_mask_i, mold_msg_data_i,
    input  itch_msg_v_o, itch_msg_len_o, itch_msg_data_o,
           asm_err_ovf_o, asm_err_trunc_o, asm_err_orphan_o, asm_err_len_o
`ifdef MOLD_ASM_CNT_EN
           , asm_msg_cnt_o, asm_drop_cnt_o
`endif
  );

  modport slave (
    input  mold_msg_v_i, mold_msg_start_i, mold_msg_len_i, mold_msg_mask_i, mold_msg_data_i,
    output itch_msg_v_o, itch_msg_len_o, itch_msg_data_o,
           asm_err_ovf_o, asm_err_trunc_o, asm_err_orphan_o, asm_err_len_o
`ifdef MOLD_ASM_CNT_EN
           , asm_msg_cnt_o, asm_drop_cnt_o
`endif
  );

endinterface

// File: rtl/mold_msg_asm_place.sv
// Places the first i_nbytes bytes of a beat at byte offset i_offset of the
// flat message buffer; lanes at or beyond MSG_MAX_LEN are never enabled.
module mold_asm_place
  import mold_pkg::*;
(
  input  logic [ML_W-1:0]        i_offset,
  input  logic [POP_W-1:0]       i_nbytes,
  input  logic [AXI_DATA_W-1:0]  i_data,
  output logic [MSG_W-1:0]       o_data,
  output logic [MSG_MAX_LEN-1:0] o_we
);

  always_comb begin
    o_data = '0;
    o_we   = '0;
    for (int unsigned k = 0; k < MSG_MAX_LEN; k++) begin
      for (int unsigned j = 0; j < AXI_KEEP_W; j++) begin
        if ((32'(i_offset) + j == k) && (j < 32'(i_nbytes))) begin
          o_we[k]          = 1'b1;
          o_data[8*k +: 8] = i_data[8*j +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mold_msg_asm.sv
// Reassembles MoldUDP64 message beats into one flat register and flags
// malformed sequences. MOLD_ASM_CNT_EN adds message/drop counters.
module mold_msg_asm
  import mold_pkg::*;
(
  input  logic           clk,
  input  logic           nreset,
  mold_msg_asm_if.slave  bus
);

  mold_asm_state_e        r_state, w_state_d;
  logic [ML_W-1:0]        r_cnt, w_cnt_d;
  logic [ML_W-1:0]        r_len, w_len_d;
  logic [MSG_W-1:0]       r_buf, w_buf_d;
  logic                   r_itch_v;
  logic [ML_W-1:0]        r_itch_len;
  logic [MSG_W-1:0]       r_itch_data;
  logic                   r_ovf, r_trunc, r_orphan, r_lenerr;

  logic [POP_W-1:0]       w_pop;
  logic                   w_len_ok;
  logic [ML_W:0]          w_sum;
  logic [ML_W-1:0]        w_rem;
  logic                   w_clear, w_wr, w_done;
  logic                   w_ovf, w_trunc, w_orphan, w_lenerr;
  logic [ML_W-1:0]        w_offset;
  logic [POP_W-1:0]       w_nbytes;
  logic [MSG_W-1:0]       w_place;
  logic [MSG_MAX_LEN-1:0] w_place_we;

  assign w_pop    = popcount(bus.mold_msg_mask_i);
  assign w_len_ok = (bus.mold_msg_len_i != '0) && (bus.mold_msg_len_i <= ML_W'(MSG_MAX_LEN));
  assign w_sum    = {1'b0, r_cnt} + (ML_W+1)'(w_pop);
  assign w_rem    = r_len - r_cnt;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_len_d   = r_len;
    w_clear   = 1'b0;
    w_wr      = 1'b0;
    w_done    = 1'b0;
    w_offset  = r_cnt;
    w_nbytes  = w_pop;
    w_ovf     = 1'b0;
    w_trunc   = 1'b0;
    w_orphan  = 1'b0;
    w_lenerr  = 1'b0;
    if (bus.mold_msg_v_i) begin
      if (bus.mold_msg_start_i) begin
        // A start always restarts assembly, whatever state we were in.
        w_trunc = (r_state != IDLE);
        w_len_d = bus.mold_msg_len_i;
        w_cnt_d = ML_W'(w_pop);
        if (w_len_ok) begin
          w_clear  = 1'b1;
          w_wr     = 1'b1;
          w_offset = '0;
          if (ML_W'(w_pop) >= bus.mold_msg_len_i) begin
            w_done    = 1'b1;
            w_nbytes  = POP_W'(bus.mold_msg_len_i);
            w_state_d = IDLE;
          end else begin
            w_state_d = ACC;
          end
        end else begin
          w_ovf     = 1'b1;
          w_state_d = (bus.mold_msg_len_i > ML_W'(w_pop)) ? DROP : IDLE;
        end
      end else begin
        case (r_state)
          IDLE: w_orphan = 1'b1;
          ACC: begin
            w_wr    = 1'b1;
            w_cnt_d = w_sum[ML_W-1:0];
            if (w_sum >= {1'b0, r_len}) begin
              w_done    = 1'b1;
              w_lenerr  = (w_sum != {1'b0, r_len});
              w_state_d = IDLE;
              if (w_rem < ML_W'(w_pop)) w_nbytes = POP_W'(w_rem);
            end
          end
          DROP: begin
            w_cnt_d = w_sum[ML_W-1:0];
            if (w_sum >= {1'b0, r_len}) w_state_d = IDLE;
          end
          default: w_state_d = IDLE;
        endcase
      end
    end
  end

  mold_asm_place u_place (
    .i_offset (w_offset),
    .i_nbytes (w_nbytes),
    .i_data   (bus.mold_msg_data_i),
    .o_data   (w_place),
    .o_we     (w_place_we)
  );

  always_comb begin
    w_buf_d = w_clear ? '0 : r_buf;
    for (int unsigned k = 0; k < MSG_MAX_LEN; k++) begin
      if (w_wr && w_place_we[k]) w_buf_d[8*k +: 8] = w_place[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_buf       <= '0;
      r_itch_v    <= 1'b0;
      r_itch_len  <= '0;
      r_itch_data <= '0;
      r_ovf       <= 1'b0;
      r_trunc     <= 1'b0;
      r_orphan    <= 1'b0;
      r_lenerr    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_len    <= w_len_d;
      r_buf    <= w_buf_d;
      r_itch_v <= w_done;
      r_ovf    <= w_ovf;
      r_trunc  <= w_trunc;
      r_orphan <= w_orphan;
      r_lenerr <= w_lenerr;
      if (w_done) begin
        r_itch_len  <= w_len_d;
        r_itch_data <= w_buf_d;
      end
    end
  end

  assign bus.itch_msg_v_o     = r_itch_v;
  assign bus.itch_msg_len_o   = r_itch_len;
  assign bus.itch_msg_data_o  = r_itch_data;
  assign bus.asm_err_ovf_o    = r_ovf;
  assign bus.asm_err_trunc_o  = r_trunc;
  assign bus.asm_err_orphan_o = r_orphan;
  assign bus.asm_err_len_o    = r_lenerr;

`ifdef MOLD_ASM_CNT_EN
  logic [31:0] r_msg_cnt, r_drop_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_msg_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_msg_cnt  <= r_msg_cnt + 32'(w_done);
      r_drop_cnt <= r_drop_cnt + 32'(w_ovf) + 32'(w_trunc) + 32'(w_orphan);
    end
  end

  assign bus.asm_msg_cnt_o  = r_msg_cnt;
  assign bus.asm_drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_mold_msg_asm.sv
// Self-checking bench for mold_msg_asm: directed vector table, reset corner case,
// then random beats against a queue-based message model.
module tb_mold_msg_asm;
  import mold_pkg::*;

  logic clk;
  logic nreset;
  int   n_chk;
  int   n_fail;

  mold_msg_asm_if bus ();

  mold_msg_asm dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic             s;
    logic [15:0]      len;
    logic [7:0]       mask;
    logic [63:0]      data;
    logic             ev;
    logic [15:0]      elen;
    logic [MSG_W-1:0] edata;
    logic [3:0]       eerr;  // {ovf, trunc, orphan, len}
  } vec_t;

  vec_t             tbl[$];
  logic [15:0]      exp_len;
  logic [MSG_W-1:0] exp_data;
  logic             e_v;
  logic [3:0]       e_err;
  int unsigned      m_mcnt, m_dcnt;

  // Reference model: a message is just a queue of bytes plus its declared length.
  bit   m_act, m_drop;
  int   m_need, m_got;
  byte  q[$];

  function automatic void chk(string name, logic [MSG_W-1:0] act, logic [MSG_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic v, logic s, int len, logic [7:0] m, logic [63:0] d,
                              logic ev, int elen, logic [MSG_W-1:0] ed, logic [3:0] er);
    vec_t r;
    r.v = v; r.s = s; r.len = 16'(len); r.mask = m; r.data = d;
    r.ev = ev; r.elen = 16'(elen); r.edata = ed; r.eerr = er;
    return r;
  endfunction

  task automatic beat(input logic v, input logic s, input logic [15:0] len,
                      input logic [7:0] m, input logic [63:0] d);
    bus.mold_msg_v_i     = v;
    bus.mold_msg_start_i = s;
    bus.mold_msg_len_i   = len;
    bus.mold_msg_mask_i  = m;
    bus.mold_msg_data_i  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dut_err();
    return {bus.asm_err_ovf_o, bus.asm_err_trunc_o, bus.asm_err_orphan_o, bus.asm_err_len_o};
  endfunction

  task automatic check_outputs(string tag);
    chk({tag, "_v"}, MSG_W'(bus.itch_msg_v_o), MSG_W'(e_v));
    chk({tag, "_err"}, MSG_W'(dut_err()), MSG_W'(e_err));
    chk({tag, "_len"}, MSG_W'(bus.itch_msg_len_o), MSG_W'(exp_len));
    chk({tag, "_data"}, bus.itch_msg_data_o, exp_data);
`ifdef MOLD_ASM_CNT_EN
    chk({tag, "_mcnt"}, MSG_W'(bus.asm_msg_cnt_o), MSG_W'(m_mcnt));
    chk({tag, "_dcnt"}, MSG_W'(bus.asm_drop_cnt_o), MSG_W'(m_dcnt));
`endif
  endtask

  function automatic void emit(int len);
    e_v      = 1'b1;
    exp_len  = 16'(len);
    exp_data = '0;
    foreach (q[k]) exp_data[8*k +: 8] = q[k];
    m_mcnt++;
  endfunction

  function automatic void model_beat(logic v, logic s, int len, int pop, logic [63:0] d);
    e_v   = 1'b0;
    e_err = '0;
    if (!v) return;
    if (s) begin
      if (m_act || m_drop) e_err[2] = 1'b1;
      m_act = 0; m_drop = 0;
      q.delete();
      if (len == 0 || len > int'(MSG_MAX_LEN)) begin
        e_err[3] = 1'b1;
        if (len > pop) begin m_drop = 1; m_need = len; m_got = pop; end
      end else begin
        for (int j = 0; j < pop && j < len; j++) q.push_back(byte'(d[8*j +: 8]));
        if (pop >= len) emit(len);
        else begin m_act = 1; m_need = len; end
      end
    end else if (m_drop) begin
      m_got += pop;
      if (m_got >= m_need) m_drop = 0;
    end else if (m_act) begin
      for (int j = 0; j < pop; j++) begin
        if (q.size() < m_need) q.push_back(byte'(d[8*j +: 8]));
        else e_err[0] = 1'b1;
      end
      if (q.size() == m_need) begin emit(m_need); m_act = 0; end
    end else begin
      e_err[1] = 1'b1;
    end
    m_dcnt += int'(e_err[3]) + int'(e_err[2]) + int'(e_err[1]);
  endfunction

  initial begin
    n_chk = 0; n_fail = 0;
    exp_len = '0; exp_data = '0; e_v = 0; e_err = '0;
    m_mcnt = 0; m_dcnt = 0;
    m_act = 0; m_drop = 0; m_need = 0; m_got = 0;
    nreset = 1'b0;
    bus.mold_msg_v_i = 0; bus.mold_msg_start_i = 0; bus.mold_msg_len_i = '0;
    bus.mold_msg_mask_i = '0; bus.mold_msg_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    nreset = 1'b1;

    tbl.push_back(mk(1, 1, 16, 8'hFF, {16{4'hA}}, 0, 0, '0, 4'b0000));
    tbl.push_back(mk(1, 0, 0,  8'hFF, {16{4'hB}}, 1, 16,
                     MSG_W'({{8{8'hBB}}, {8{8'hAA}}}), 4'b0000));
    tbl.push_back(mk(0, 0, 0,  8'h00, 64'h0, 0, 0, '0, 4'b0000));
    tbl.push_back(mk(1, 1, 5,  8'h1F, 64'h1122334455, 1, 5, MSG_W'(40'h1122334455), 4'b0000));
    tbl.push_back(mk(1, 1, 5,  8'h1F, 64'h1122334455, 1, 5, MSG_W'(40'h1122334455), 4'b0000));
    tbl.push_back(mk(1, 1, 60, 8'hFF, 64'h0, 0, 0, '0, 4'b1000));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 0, 0, 8'hFF, 64'h0, 0, 0, '0, 4'b0000));
    tbl.push_back(mk(1, 1, 8,  8'hFF, 64'h8877665544332211, 1, 8,
                     MSG_W'(64'h8877665544332211), 4'b0000));
    tbl.push_back(mk(1, 1, 16, 8'hFF, {8{8'hCC}}, 0, 0, '0, 4'b0000));
    tbl.push_back(mk(1, 1, 8,  8'hFF, {8{8'hDD}}, 1, 8, MSG_W'({8{8'hDD}}), 4'b0100));
    tbl.push_back(mk(1, 0, 0,  8'hFF, {8{8'hEE}}, 0, 0, '0, 4'b0010));
    tbl.push_back(mk(1, 1, 10, 8'hFF, 64'h0807060504030201, 0, 0, '0, 4'b0000));
    tbl.push_back(mk(1, 0, 0,  8'hFF, 64'h100F0E0D0C0B0A09, 1, 10,
                     MSG_W'(80'h0A090807060504030201), 4'b0001));
    tbl.push_back(mk(1, 1, 0,  8'hFF, 64'h0, 0, 0, '0, 4'b1000));
    tbl.push_back(mk(1, 0, 0,  8'h03, 64'h0, 0, 0, '0, 4'b0010));

    foreach (tbl[i]) begin
      beat(tbl[i].v, tbl[i].s, tbl[i].len, tbl[i].mask, tbl[i].data);
      e_v   = tbl[i].ev;
      e_err = tbl[i].eerr;
      if (tbl[i].ev) begin exp_len = tbl[i].elen; exp_data = tbl[i].edata; m_mcnt++; end
      m_dcnt += int'(e_err[3]) + int'(e_err[2]) + int'(e_err[1]);
      check_outputs("vec");
    end

    // Reset in the middle of a message: partial message vanishes silently.
    beat(1, 1, 16, 8'hFF, {8{8'h5A}});
    nreset = 1'b0;
    #3;
    exp_len = '0; exp_data = '0; e_v = 0; e_err = '0; m_mcnt = 0; m_dcnt = 0;
    check_outputs("in_reset");
    @(posedge clk);
    #1;
    nreset = 1'b1;
    beat(1, 1, 16, 8'hFF, {8{8'h11}});
    check_outputs("post_rst_a");
    beat(1, 0, 0, 8'hFF, {8{8'h22}});
    e_v = 1; exp_len = 16; exp_data = MSG_W'({{8{8'h22}}, {8{8'h11}}}); m_mcnt = 1;
    check_outputs("post_rst_b");
    beat(0, 0, 0, 8'h00, 64'h0);
    e_v = 0;
    check_outputs("post_rst_c");

    for (int i = 0; i < 2500; i++) begin
      logic        v, s;
      int          len, pop;
      logic [7:0]  m;
      logic [63:0] d;
      v = ($urandom_range(0, 99) < 85);
      s = (m_act || m_drop) ? ($urandom_range(0, 99) < 12) : ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 60);
      else len = $urandom_range(1, 50);
      pop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : 8;
      m = 8'((16'd1 << pop) - 16'd1);
      d = {$urandom(), $urandom()};
      model_beat(v, s, len, pop, d);
      beat(v, s, 16'(len), m, d);
      check_outputs("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
